// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types, default constants and helpers for the UART blocks.
//  Contents : rx_state_e   - receiver FSM state encoding
//             c_DEF_*      - default DATA_WIDTH / OVERSAMPLE / DIV_W values
//             parity_calc  - expected parity bit for a (zero-extended) char
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int c_DEF_DATA_WIDTH = 8;
  localparam int c_DEF_OVERSAMPLE = 16;
  localparam int c_DEF_DIV_W      = 16;

  // Widest character any UART block supports; narrower characters are
  // zero-extended to this width before parity is computed.
  localparam int c_PAR_MAX_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Zero padding does not change an XOR reduction, so one function covers
  // every legal character width. Odd parity is the inverted even parity.
  function automatic logic parity_calc(input logic [c_PAR_MAX_W-1:0] data,
                                       input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_core_if.sv
// ============================================================================
//  Module   : uart_rx_core_if
//  Purpose  : Character valid/ready port of the UART receiver.
//  Signals  : rx_data    - received character, LSB received first
//             rx_valid   - rx_data and error flags are valid
//             rx_ready   - consumer accepts when rx_valid && rx_ready
//             parity_err - parity mismatch for the held character
//             frame_err  - stop bit sampled low for the held character
//  Modports : master (receiver side), slave (consumer side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  parity_err;
  logic                  frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    output parity_err,
    output frame_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  parity_err,
    input  frame_err,
    output rx_ready
  );

endinterface

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================================
//  Module   : uart_baud_tick
//  Purpose  : Oversample tick generator. A counter runs 0..div and emits a
//             registered one-cycle tick each time it wraps.
//  Ports    : pclk    - system clock
//             areset  - asynchronous, active-high reset
//             div     - pclk cycles per tick, minus 1 (0 = tick every cycle)
//             restart - synchronously clears the counter (phase alignment)
//             tick    - one-cycle pulse per oversample period
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  wire              pclk,
  input  wire              areset,
  input  wire [DIV_W-1:0]  div,
  input  wire              restart,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tick;

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == div) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/uart_rx_core.sv
// ============================================================================
//  Module   : uart_rx_core
//  Purpose  : UART receiver. Synchronizes and oversamples rx, deframes
//             start/data/parity/stop and presents each character on a
//             valid/ready port holding one character plus error status.
//  Ports    : pclk       - system clock
//             areset     - asynchronous, active-high reset
//             baud_div   - pclk cycles per oversample tick, minus 1
//             parity_en  - 1 = parity bit present
//             parity_odd - 1 = odd parity, 0 = even parity
//             rx         - serial line, idle high
//             rx_if      - character port (master side)
//             overrun    - one-cycle pulse: a character was dropped
//             busy       - high whenever the FSM is not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int OVERSAMPLE = c_DEF_OVERSAMPLE,
  parameter int DIV_W      = c_DEF_DIV_W
) (
  input  wire              pclk,
  input  wire              areset,
  input  wire [DIV_W-1:0]  baud_div,
  input  wire              parity_en,
  input  wire              parity_odd,
  input  wire              rx,
  uart_rx_core_if.master   rx_if,
  output logic             overrun,
  output logic             busy
);

  localparam int                c_OS_W      = $clog2(OVERSAMPLE);
  localparam int                c_BIT_W     = $clog2(DATA_WIDTH);
  localparam logic [c_OS_W-1:0] c_HALF_LAST = c_OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_OS_W-1:0] c_FULL_LAST = c_OS_W'(OVERSAMPLE - 1);
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);

  // --------------------------------------------------------------------------
  // Synchronizer: r_rx_meta -> r_rx_s, plus r_rx_d for edge detection.
  // --------------------------------------------------------------------------
  logic r_rx_meta;
  logic r_rx_s;
  logic r_rx_d;

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  logic w_fall;
  assign w_fall = r_rx_d & ~r_rx_s;

  // --------------------------------------------------------------------------
  // Tick generator, phase-aligned to the detected start edge.
  // --------------------------------------------------------------------------
  rx_state_e        r_state;
  logic [DIV_W-1:0] r_div;
  logic             w_restart;
  logic             w_tick;

  assign w_restart = (r_state == IDLE) && w_fall;

  uart_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .pclk    (pclk),
    .areset  (areset),
    .div     (r_div),
    .restart (w_restart),
    .tick    (w_tick)
  );

  // --------------------------------------------------------------------------
  // Deframing FSM
  // --------------------------------------------------------------------------
  logic [c_OS_W-1:0]     r_os_cnt;
  logic [c_BIT_W-1:0]    r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_perr;
  logic                  r_ferr;
  logic                  r_load;
  logic                  r_busy;
  logic [c_PAR_MAX_W-1:0] w_data_ext;
  logic                  w_os_done;

  always_comb begin
    w_data_ext                 = '0;
    w_data_ext[DATA_WIDTH-1:0] = r_shift;
  end

  // Bit-centre sample point for DATA / PARITY / STOP.
  assign w_os_done = w_tick && (r_os_cnt == c_FULL_LAST);

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_div     <= '0;
      r_os_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_load    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_load <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state  <= START;
            r_busy   <= 1'b1;
            r_div    <= baud_div;
            r_os_cnt <= '0;
          end
        end

        START: begin
          if (w_tick) begin
            if (r_os_cnt == c_HALF_LAST) begin
              r_os_cnt <= '0;
              if (r_rx_s) begin
                // Line went back high before mid-bit: a glitch, not a start.
                r_state <= IDLE;
                r_busy  <= 1'b0;
              end else begin
                r_state   <= DATA;
                r_bit_cnt <= '0;
              end
            end else begin
              r_os_cnt <= r_os_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (w_os_done) begin
            r_os_cnt <= '0;
            r_shift  <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
            if (r_bit_cnt == c_LAST_BIT) begin
              r_perr  <= 1'b0;
              r_state <= parity_en ? PARITY : STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (w_os_done) begin
            r_os_cnt <= '0;
            r_perr   <= (r_rx_s != parity_calc(w_data_ext, parity_odd));
            r_state  <= STOP;
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end

        STOP: begin
          if (w_os_done) begin
            r_os_cnt <= '0;
            r_ferr   <= ~r_rx_s;
            r_load   <= 1'b1;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
          end else if (w_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer: one held character. A load that meets an unaccepted
  // character is dropped (overrun); a load coinciding with an accept wins.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_perr_o;
  logic                  r_ferr_o;
  logic                  r_overrun;

  always_ff @(posedge pclk or posedge areset) begin
    if (areset) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_perr_o  <= 1'b0;
      r_ferr_o  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_load) begin
        if (!r_valid || rx_if.rx_ready) begin
          r_data   <= r_shift;
          r_perr_o <= r_perr & parity_en;
          r_ferr_o <= r_ferr;
          r_valid  <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx_if.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_valid   = r_valid;
  assign rx_if.parity_err = r_perr_o;
  assign rx_if.frame_err  = r_ferr_o;
  assign overrun          = r_overrun;
  assign busy             = r_busy;

endmodule

`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Synthesizable UART receiver for the `uart_if` `tx` line; it is the serial consumer that the device agent BFM drives in the testbench top.
- Synchronizes and oversamples the serial line, deframes start/data/parity/stop, and presents each character on a valid/ready port.
- Holds one character, plus parity, framing and overrun status.

Parameters:
- DATA_WIDTH, 8: data bits per character; legal range 5..8.
- OVERSAMPLE, 16: oversample ticks per bit; must be even and at least 4.
- DIV_W, 16: width of the baud divisor.

Ports:
- pclk  input  1  system clock
- areset  input  1  asynchronous, active-high reset
- baud_div  input  DIV_W  pclk cycles per oversample tick, minus 1
- parity_en  input  1  1 = parity bit present
- parity_odd  input  1  1 = odd parity, 0 = even parity
- rx  input  1  serial line, idle high
- rx_data  output  DATA_WIDTH  received character, LSB received first
- rx_valid  output  1  rx_data and the error flags are valid
- rx_ready  input  1  consumer accepts when rx_valid && rx_ready
- parity_err  output  1  parity mismatch for the held character
- frame_err  output  1  stop bit sampled low for the held character
- overrun  output  1  one-cycle pulse: a character was dropped
- busy  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (asynchronous, active-high) sets:
  - FSM to IDLE, all counters to 0.
  - Synchronizer flops to 1.
  - rx_data = 0 and all of rx_valid, parity_err, frame_err, overrun, busy = 0.
- Reset asserted mid-frame abandons the frame; no partial character is presented.
- Synchronizer: 2-flop on rx. rx_s is the second flop; a third flop rx_d is used for edge detection.
- Tick generator: a counter counts 0..baud_div and emits a 1-cycle tick on wrap.
  - baud_div = 0 gives a tick every cycle.
  - baud_div is latched on IDLE→START; changes mid-frame are ignored.
  - The tick counter restarts on entry to START.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A falling edge (rx_d=1, rx_s=0) moves to START.
  - A line held low never re-triggers.
- START:
  - Counts OVERSAMPLE/2 ticks to mid-bit, then samples rx_s.
  - rx_s=1 → glitch: return to IDLE, no output.
  - rx_s=0 → clear the tick count and go to DATA.
- DATA:
  - Samples every OVERSAMPLE ticks, i.e. at bit centres.
  - Shifts in LSB first.
  - After DATA_WIDTH samples, go to PARITY if parity_en, else STOP.
- PARITY:
  - One sample; compare against the XOR of the data bits.
  - Even parity: expected bit = XOR. Odd parity: expected bit = ~XOR.
- STOP:
  - One sample; rx_s=0 sets frame error.
  - Go to IDLE on the same cycle as the sample.
- Output buffer:
  - One cycle after the stop sample, load rx_data, parity_err and frame_err, and set rx_valid.
  - parity_err is forced to 0 when parity_en=0.
- Handshake:
  - rx_valid stays high until rx_valid && rx_ready.
  - The outputs hold stable while rx_valid=1 and rx_ready=0.
- Simultaneous events:
  - Load and accept in the same cycle: the new character wins and rx_valid stays 1.
  - Load while rx_valid=1 and not accepted: the new character is dropped, the old one is kept, and overrun pulses for 1 cycle.
- Frame error (including a break): the character is still delivered with frame_err=1. A new frame needs a fresh falling edge.
- Latency from the rx start edge to rx_valid, with tick period T cycles: ≈ 2 + T·(OVERSAMPLE/2 + OVERSAMPLE·(DATA_WIDTH + parity_en + 1)) + 1 cycles.

Decomposition:
- uart_pkg:
  - rx_state_e enum (IDLE, START, DATA, PARITY, STOP).
  - Default constants: DATA_WIDTH, OVERSAMPLE, DIV_W.
  - parity_calc function.
- Sub-module uart_baud_tick:
  - Inputs: pclk, areset, div, restart.
  - Output: tick.
  - Reused by the future transmitter.

Test Plan (all with baud_div=0, OVERSAMPLE=16, so 16 cycles per bit):
- 8N1 frame 0xA5, rx_ready=1 → rx_data=0xA5, rx_valid for 1 cycle, parity_err=0, frame_err=0, busy low after the stop bit.
- parity_en=1, parity_odd=0, data 0x03 with parity bit 1 → parity_err=1, rx_data=0x03. Repeat with parity bit 0 → parity_err=0.
- Low pulse on rx of 4 cycles → no rx_valid, busy returns to 0 within 8 ticks, and the next 0x5A frame is received correctly.
- Stop bit driven 0 for frame 0x3C → rx_data=0x3C and frame_err=1. With the line held low for 2 more bit times, no second character appears.
- rx_ready=0 while sending 0x11 then 0x22 back-to-back → rx_data stays 0x11 and overrun pulses once. Then rx_ready=1 → 0x11 accepted and rx_valid drops.
- areset asserted mid-way through data bit 3 → all outputs 0 and FSM IDLE. The following frame 0xFF is received correctly.
